nic_ctrl_amm_to_csr: RTL

- Avalon-MM slave that turns 32-bit host accesses from the HPS lightweight bridge into 16-bit csr_if master transactions on the NIC control register file.
- It is the initiator side of the csr_if bus whose slave is the NIC control regfile.
- Each Avalon word maps to two consecutive 16-bit CSR words: low half first, then high half.
- One transaction is outstanding at a time. The host is stalled with amm_waitrequest_o until the transaction completes.

---
 rtl/nic_ctrl_csr_pkg.sv | 24 ++
 rtl/nic_ctrl_amm_to_csr_if.sv | 37 +++
 rtl/nic_ctrl_amm_to_csr.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nic_ctrl_csr_pkg.sv
// rtl/nic_ctrl_csr_pkg.sv - shared types, constants and address helper for the AMM-to-CSR bridge
package nic_ctrl_csr_pkg;

  localparam int   AMM_DW  = 32;
  localparam int   CSR_AW  = 10;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_t;

  // One Avalon word covers two CSR words; the half selects the low or high one.
  function automatic logic [CSR_AW-1:0] amm_to_csr_addr(input logic [CSR_AW-2:0] addr,
                                                        input logic              half);
    return {addr, half};
  endfunction

endpackage

// File: rtl/nic_ctrl_amm_to_csr_if.sv
// rtl/nic_ctrl_amm_to_csr_if.sv - host Avalon-MM and regfile csr_if signals of the bridge
interface nic_ctrl_amm_to_csr_if #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 16
);
  localparam int AMM_AW = A_WIDTH - 1;

  logic [AMM_AW-1:0]    amm_address_i;
  logic                 amm_write_i;
  logic                 amm_read_i;
  logic [2*D_WIDTH-1:0] amm_writedata_i;
  logic [3:0]           amm_byteenable_i;
  logic [2*D_WIDTH-1:0] amm_readdata_o;
  logic                 amm_waitrequest_o;
  logic [A_WIDTH-1:0]   csr_addr_o;
  logic                 csr_wr_en_o;
  logic [D_WIDTH-1:0]   csr_wr_data_o;
  logic [1:0]           csr_be_o;
  logic [D_WIDTH-1:0]   csr_rd_data_i;

  // Bridge view: answers the host, drives the regfile.
  modport slave (
    input  amm_address_i, amm_write_i, amm_read_i, amm_writedata_i, amm_byteenable_i,
    input  csr_rd_data_i,
    output amm_readdata_o, amm_waitrequest_o,
    output csr_addr_o, csr_wr_en_o, csr_wr_data_o, csr_be_o
  );

  // Environment view: host plus regfile.
  modport master (
    output amm_address_i, amm_write_i, amm_read_i, amm_writedata_i, amm_byteenable_i,
    output csr_rd_data_i,
    input  amm_readdata_o, amm_waitrequest_o,
    input  csr_addr_o, csr_wr_en_o, csr_wr_data_o, csr_be_o
  );

endinterface

// File: rtl/nic_ctrl_amm_to_csr.sv
// rtl/nic_ctrl_amm_to_csr.sv - splits 32-bit Avalon-MM accesses into two 16-bit csr_if transactions
module nic_ctrl_amm_to_csr
  import nic_ctrl_csr_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = CSR_AW,
  parameter int AMM_AW  = A_WIDTH - 1,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  nic_ctrl_amm_to_csr_if.slave  bus,
  output logic                  protocol_err_o
);

  state_t               state, nxt_state;
  logic [AMM_AW-1:0]    addr_q, nxt_addr;
  logic [AMM_DW-1:0]    data_q, nxt_data;
  logic [3:0]           be_q, nxt_be;
  logic                 half_q, nxt_half;
  logic [1:0]           cnt_q, nxt_cnt;
  logic [AMM_DW-1:0]    rdata_q, nxt_rdata;
  logic                 perr_q, nxt_perr;
  logic [A_WIDTH-1:0]   csr_addr_q, nxt_csr_addr;
  logic [D_WIDTH-1:0]   csr_data_q, nxt_csr_data;
  logic [1:0]           csr_be_q, nxt_csr_be;
  logic                 wr_en_q, nxt_wr_en;
  logic                 waitreq_q, nxt_waitreq;

  // Next state and next value of every registered output; outputs are derived
  // from the state being entered so each strobe lines up with its own state.
  always_comb begin
    nxt_state    = state;
    nxt_addr     = addr_q;
    nxt_data     = data_q;
    nxt_be       = be_q;
    nxt_half     = half_q;
    nxt_cnt      = cnt_q;
    nxt_rdata    = rdata_q;
    nxt_perr     = perr_q;
    nxt_csr_addr = csr_addr_q;
    nxt_csr_data = csr_data_q;
    nxt_csr_be   = csr_be_q;
    nxt_wr_en    = 1'b0;
    nxt_waitreq  = 1'b1;

    case (state)
      IDLE: begin
        if (bus.amm_write_i || bus.amm_read_i) begin
          nxt_addr = bus.amm_address_i;
          nxt_data = bus.amm_writedata_i;
          nxt_be   = bus.amm_byteenable_i;
          nxt_half = HALF_LO;
          // Write wins a simultaneous request; the dropped read is flagged.
          if (bus.amm_write_i && bus.amm_read_i) nxt_perr = 1'b1;
          nxt_state = bus.amm_write_i ? WR_LO : RD_ISSUE;
        end
      end
      WR_LO:    nxt_state = WR_HI;
      WR_HI:    nxt_state = DONE;
      RD_ISSUE: begin
        nxt_cnt   = 2'(RD_LAT - 1);
        nxt_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (half_q == HALF_LO) begin
            nxt_rdata[D_WIDTH-1:0] = bus.csr_rd_data_i;
            nxt_half               = HALF_HI;
            nxt_state              = RD_ISSUE;
          end else begin
            nxt_rdata[AMM_DW-1:D_WIDTH] = bus.csr_rd_data_i;
            nxt_state                   = DONE;
          end
        end else begin
          nxt_cnt = cnt_q - 2'd1;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    case (nxt_state)
      WR_LO: begin
        nxt_csr_addr = amm_to_csr_addr(nxt_addr, HALF_LO);
        nxt_csr_data = nxt_data[D_WIDTH-1:0];
        nxt_csr_be   = nxt_be[1:0];
        nxt_wr_en    = |nxt_be[1:0];
      end
      WR_HI: begin
        nxt_csr_addr = amm_to_csr_addr(nxt_addr, HALF_HI);
        nxt_csr_data = nxt_data[AMM_DW-1:D_WIDTH];
        nxt_csr_be   = nxt_be[3:2];
        nxt_wr_en    = |nxt_be[3:2];
      end
      // Address set here stays put through RD_WAIT since nothing else updates it.
      RD_ISSUE: nxt_csr_addr = amm_to_csr_addr(nxt_addr, nxt_half);
      DONE:     nxt_waitreq  = 1'b0;
      default:  ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      half_q     <= HALF_LO;
      cnt_q      <= '0;
      rdata_q    <= '0;
      perr_q     <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      csr_be_q   <= '0;
      wr_en_q    <= 1'b0;
      waitreq_q  <= 1'b1;
    end else begin
      state      <= nxt_state;
      addr_q     <= nxt_addr;
      data_q     <= nxt_data;
      be_q       <= nxt_be;
      half_q     <= nxt_half;
      cnt_q      <= nxt_cnt;
      rdata_q    <= nxt_rdata;
      perr_q     <= nxt_perr;
      csr_addr_q <= nxt_csr_addr;
      csr_data_q <= nxt_csr_data;
      csr_be_q   <= nxt_csr_be;
      wr_en_q    <= nxt_wr_en;
      waitreq_q  <= nxt_waitreq;
    end
  end

  assign bus.amm_readdata_o    = rdata_q;
  assign bus.amm_waitrequest_o = waitreq_q;
  assign bus.csr_addr_o        = csr_addr_q;
  assign bus.csr_wr_en_o       = wr_en_q;
  assign bus.csr_wr_data_o     = csr_data_q;
  assign bus.csr_be_o          = csr_be_q;
  assign protocol_err_o        = perr_q;

endmodule
